// File: rtl/v_issue_ctrl_if.sv
// v_issue_ctrl_if: decoder/functional-unit bundle for the vector issue controller.
//   Decoder side : instr_valid/instr_ready handshake, decoded opcodes, reg_wr_req
//   Unit side    : per-unit done inputs, registered clock enables, latched opcodes
//   Status       : vconfig_wr_en, wb_en, stall, sticky illegal/timeout errors
//   slave  modport: the controller; master modport: the decoder/unit environment.
interface v_issue_ctrl_if;
   logic       instr_valid;
   logic       instr_ready;
   logic [3:0] alu_op;
   logic       is_mul;
   logic [3:0] lsu_op;
   logic [2:0] sldu_op;
   logic [2:0] red_op;
   logic       is_vconfig;
   logic       reg_wr_req;
   logic       done_valu;
   logic       done_vmul;
   logic       done_vred;
   logic       done_vsldu;
   logic       done_vload;
   logic       done_store;
   logic       err_clr;
   logic [3:0] alu_op_q;
   logic       is_mul_q;
   logic [3:0] lsu_op_q;
   logic [2:0] sldu_op_q;
   logic [2:0] red_op_q;
   logic       valu_clk_en;
   logic       vmul_clk_en;
   logic       vred_clk_en;
   logic       vsldu_clk_en;
   logic       vlsu_clk_en;
   logic       vconfig_wr_en;
   logic       wb_en;
   logic       stall;
   logic       illegal_err;
   logic       timeout_err;

   modport slave (
      input  instr_valid, alu_op, is_mul, lsu_op, sldu_op, red_op, is_vconfig, reg_wr_req,
      input  done_valu, done_vmul, done_vred, done_vsldu, done_vload, done_store, err_clr,
      output instr_ready, alu_op_q, is_mul_q, lsu_op_q, sldu_op_q, red_op_q,
      output valu_clk_en, vmul_clk_en, vred_clk_en, vsldu_clk_en, vlsu_clk_en,
      output vconfig_wr_en, wb_en, stall, illegal_err, timeout_err
   );

   modport master (
      output instr_valid, alu_op, is_mul, lsu_op, sldu_op, red_op, is_vconfig, reg_wr_req,
      output done_valu, done_vmul, done_vred, done_vsldu, done_vload, done_store, err_clr,
      input  instr_ready, alu_op_q, is_mul_q, lsu_op_q, sldu_op_q, red_op_q,
      input  valu_clk_en, vmul_clk_en, vred_clk_en, vsldu_clk_en, vlsu_clk_en,
      input  vconfig_wr_en, wb_en, stall, illegal_err, timeout_err
   );
endinterface

// File: rtl/v_issue_ctrl.sv
// v_issue_ctrl: single-issue sequencer between the vector decoder and the units.
//   clk, rst : core clock, asynchronous active-high reset
//   bus      : v_issue_ctrl_if.slave (handshake, opcodes, dones, enables, status)
// Accepts one instruction in IDLE, checks it names exactly one unit, enables only
// that unit's clock until its done (or a timeout), then pulses writeback.
module v_issue_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic           clk,
   input  logic           rst,
   v_issue_ctrl_if.slave  bus
);

   localparam int unsigned N_EN = 5;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_CFG, S_EXEC, S_WB, S_ABORT} state_t;
   typedef enum logic [2:0] {U_VALU, U_VMUL, U_VRED, U_VSLDU, U_VLOAD, U_VSTORE} unit_t;

   state_t           state;
   unit_t            unit_q;
   logic [CNT_W-1:0] cnt;
   logic [N_EN-1:0]  en_q;
   logic             reg_wr_q;
   logic [3:0]       alu_op_q;
   logic             is_mul_q;
   logic [3:0]       lsu_op_q;
   logic [2:0]       sldu_op_q;
   logic [2:0]       red_op_q;
   logic             vconfig_wr_en_q;
   logic             wb_en_q;
   logic             illegal_err_q;
   logic             timeout_err_q;

   logic             accept_c;
   logic [2:0]       req_cnt_c;
   logic             lsu_bad_c;
   logic             is_store_c;
   logic             illegal_c;
   logic             cfg_c;
   logic             fu_c;
   unit_t            unit_c;
   logic [N_EN-1:0]  unit_en_c;
   logic             done_sel_c;

   // Accept-time decode: request count, legality and target unit.
   always_comb begin
      accept_c   = bus.instr_valid & (state == S_IDLE);
      req_cnt_c  = 3'(bus.alu_op != 4'd0) + 3'(bus.is_mul) + 3'(bus.lsu_op != 4'd0) +
                   3'(bus.sldu_op != 3'd0) + 3'(bus.red_op != 3'd0) + 3'(bus.is_vconfig);
      lsu_bad_c  = (bus.lsu_op >= 4'd13);
      is_store_c = (bus.lsu_op >= 4'd7) & (bus.lsu_op <= 4'd12);
      illegal_c  = accept_c & ((req_cnt_c > 3'd1) | lsu_bad_c);
      cfg_c      = accept_c & ~illegal_c & (req_cnt_c == 3'd1) & bus.is_vconfig;
      fu_c       = accept_c & ~illegal_c & (req_cnt_c == 3'd1) & ~bus.is_vconfig;

      unit_c = U_VALU;
      if (bus.is_mul)                 unit_c = U_VMUL;
      else if (bus.red_op != 3'd0)    unit_c = U_VRED;
      else if (bus.sldu_op != 3'd0)   unit_c = U_VSLDU;
      else if (is_store_c)            unit_c = U_VSTORE;
      else if (bus.lsu_op != 4'd0)    unit_c = U_VLOAD;

      // Enable bit order: valu, vmul, vred, vsldu, vlsu (loads and stores share vlsu).
      unit_en_c = '0;
      case (unit_c)
         U_VALU:            unit_en_c[0] = 1'b1;
         U_VMUL:            unit_en_c[1] = 1'b1;
         U_VRED:            unit_en_c[2] = 1'b1;
         U_VSLDU:           unit_en_c[3] = 1'b1;
         U_VLOAD, U_VSTORE: unit_en_c[4] = 1'b1;
         default:           unit_en_c    = '0;
      endcase
   end

   // Only the selected unit's done is honoured.
   always_comb begin
      done_sel_c = 1'b0;
      case (unit_q)
         U_VALU:   done_sel_c = bus.done_valu;
         U_VMUL:   done_sel_c = bus.done_vmul;
         U_VRED:   done_sel_c = bus.done_vred;
         U_VSLDU:  done_sel_c = bus.done_vsldu;
         U_VLOAD:  done_sel_c = bus.done_vload;
         U_VSTORE: done_sel_c = bus.done_store;
         default:  done_sel_c = 1'b0;
      endcase
   end

   // Sequencer state, registered outputs and sticky errors.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= S_IDLE;
         unit_q          <= U_VALU;
         cnt             <= '0;
         en_q            <= '0;
         reg_wr_q        <= 1'b0;
         alu_op_q        <= '0;
         is_mul_q        <= 1'b0;
         lsu_op_q        <= '0;
         sldu_op_q       <= '0;
         red_op_q        <= '0;
         vconfig_wr_en_q <= 1'b0;
         wb_en_q         <= 1'b0;
         illegal_err_q   <= 1'b0;
         timeout_err_q   <= 1'b0;
      end else begin
         vconfig_wr_en_q <= 1'b0;
         wb_en_q         <= 1'b0;

         // A new error outranks a simultaneous clear.
         if (illegal_c)          illegal_err_q <= 1'b1;
         else if (bus.err_clr)   illegal_err_q <= 1'b0;
         if (state == S_ABORT)   timeout_err_q <= 1'b1;
         else if (bus.err_clr)   timeout_err_q <= 1'b0;

         case (state)
            S_IDLE: begin
               if (fu_c) begin
                  alu_op_q  <= bus.alu_op;
                  is_mul_q  <= bus.is_mul;
                  lsu_op_q  <= bus.lsu_op;
                  sldu_op_q <= bus.sldu_op;
                  red_op_q  <= bus.red_op;
                  reg_wr_q  <= bus.reg_wr_req & ~is_store_c;
                  unit_q    <= unit_c;
                  en_q      <= unit_en_c;
                  cnt       <= '0;
                  state     <= S_EXEC;
               end else if (cfg_c) begin
                  vconfig_wr_en_q <= 1'b1;
                  state           <= S_CFG;
               end
            end
            S_CFG: state <= S_IDLE;
            S_EXEC: begin
               // Done takes priority over reaching the timeout threshold.
               if (done_sel_c) begin
                  en_q    <= '0;
                  wb_en_q <= reg_wr_q;
                  state   <= S_WB;
               end else if (cnt == CNT_LAST) begin
                  en_q  <= '0;
                  state <= S_ABORT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_WB, S_ABORT: begin
               alu_op_q  <= '0;
               is_mul_q  <= 1'b0;
               lsu_op_q  <= '0;
               sldu_op_q <= '0;
               red_op_q  <= '0;
               reg_wr_q  <= 1'b0;
               en_q      <= '0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.instr_ready   = (state == S_IDLE);
   assign bus.stall         = bus.instr_valid & ~bus.instr_ready;
   assign bus.alu_op_q      = alu_op_q;
   assign bus.is_mul_q      = is_mul_q;
   assign bus.lsu_op_q      = lsu_op_q;
   assign bus.sldu_op_q     = sldu_op_q;
   assign bus.red_op_q      = red_op_q;
   assign bus.valu_clk_en   = en_q[0];
   assign bus.vmul_clk_en   = en_q[1];
   assign bus.vred_clk_en   = en_q[2];
   assign bus.vsldu_clk_en  = en_q[3];
   assign bus.vlsu_clk_en   = en_q[4];
   assign bus.vconfig_wr_en = vconfig_wr_en_q;
   assign bus.wb_en         = wb_en_q;
   assign bus.illegal_err   = illegal_err_q;
   assign bus.timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_v_issue_ctrl.sv
// tb_v_issue_ctrl: directed and randomized checks of v_issue_ctrl against a
// transaction-level model (expected enable length, pulses, busy time, flags).
module tb_v_issue_ctrl;
   localparam int unsigned TO = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   v_issue_ctrl_if bus ();

   v_issue_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   bit m_illegal    = 1'b0;
   bit m_timeout    = 1'b0;

   function automatic logic [4:0] en_vec();
      return {bus.vlsu_clk_en, bus.vsldu_clk_en, bus.vred_clk_en, bus.vmul_clk_en, bus.valu_clk_en};
   endfunction

   function automatic logic [14:0] q_vec();
      return {bus.alu_op_q, bus.is_mul_q, bus.lsu_op_q, bus.sldu_op_q, bus.red_op_q};
   endfunction

   task automatic clear_inputs();
      bus.instr_valid = 1'b0; bus.alu_op = '0; bus.is_mul = 1'b0; bus.lsu_op = '0;
      bus.sldu_op = '0; bus.red_op = '0; bus.is_vconfig = 1'b0; bus.reg_wr_req = 1'b0;
      bus.done_valu = 1'b0; bus.done_vmul = 1'b0; bus.done_vred = 1'b0;
      bus.done_vsldu = 1'b0; bus.done_vload = 1'b0; bus.done_store = 1'b0;
      bus.err_clr = 1'b0;
   endtask

   // Issue one instruction from IDLE and follow it until ready returns.
   task automatic run_instr(input logic [3:0] a, input logic m, input logic [3:0] l,
                            input logic [2:0] s, input logic [2:0] r, input logic cfg,
                            input logic wr, input int done_at, input logic clr, input string name);
      int nreq, unit, done_idx, exp_en, exp_busy, busy, wb_cnt, vcfg_cnt, op_bad, stall_bad, other_en;
      int en_cnt [5];
      bit illegal, vcfg, fu, store, exp_wb, got_ready;
      logic [5:0] dn;
      nreq = 0;
      if (a != 0) nreq++;
      if (m) nreq++;
      if (l != 0) nreq++;
      if (s != 0) nreq++;
      if (r != 0) nreq++;
      if (cfg) nreq++;
      illegal = (nreq > 1) || (l >= 13);
      vcfg    = !illegal && nreq == 1 && cfg;
      fu      = !illegal && nreq == 1 && !cfg;
      store   = (l >= 7) && (l <= 12);
      unit = 0; done_idx = 0;
      if (m)               begin unit = 1; done_idx = 1; end
      else if (r != 0)     begin unit = 2; done_idx = 2; end
      else if (s != 0)     begin unit = 3; done_idx = 3; end
      else if (l != 0)     begin unit = 4; done_idx = store ? 5 : 4; end
      exp_en   = fu ? ((done_at <= int'(TO)) ? done_at : int'(TO)) : 0;
      exp_wb   = fu && (done_at <= int'(TO)) && wr && !store;
      exp_busy = fu ? exp_en + 1 : (vcfg ? 1 : 0);
      if (illegal) m_illegal = 1'b1; else if (clr) m_illegal = 1'b0;
      if (clr) m_timeout = 1'b0;
      if (fu && done_at > int'(TO)) m_timeout = 1'b1;

      tests_run++;
      if (bus.instr_ready !== 1'b1) begin
         tests_failed++; $display("FAIL %s ready_before_accept got=%b exp=1", name, bus.instr_ready);
      end
      bus.alu_op = a; bus.is_mul = m; bus.lsu_op = l; bus.sldu_op = s; bus.red_op = r;
      bus.is_vconfig = cfg; bus.reg_wr_req = wr; bus.err_clr = clr; bus.instr_valid = 1'b1;
      #1;
      tests_run++;
      if (bus.stall !== 1'b0) begin
         tests_failed++; $display("FAIL %s stall_at_accept got=%b exp=0", name, bus.stall);
      end
      @(negedge clk);
      bus.err_clr = 1'b0;
      busy = 0; wb_cnt = 0; vcfg_cnt = 0; op_bad = 0; stall_bad = 0; got_ready = 1'b0;
      for (int i = 0; i < 5; i++) en_cnt[i] = 0;
      for (int c = 1; c <= 40; c++) begin
         if (bus.instr_ready === 1'b1) begin got_ready = 1'b1; break; end
         busy++;
         for (int i = 0; i < 5; i++) en_cnt[i] += int'(en_vec()[i]);
         wb_cnt   += int'(bus.wb_en);
         vcfg_cnt += int'(bus.vconfig_wr_en);
         if (fu && en_vec()[unit] && q_vec() !== {a, m, l, s, r}) op_bad++;
         // Foreign dones are random noise; the selected done fires only at done_at.
         dn = 6'($urandom);
         dn[done_idx] = (c == done_at);
         {bus.done_store, bus.done_vload, bus.done_vsldu, bus.done_vred, bus.done_vmul, bus.done_valu} = dn;
         bus.instr_valid = 1'($urandom);
         bus.alu_op = 4'($urandom); bus.lsu_op = 4'($urandom); bus.is_vconfig = 1'($urandom);
         #1;
         if (bus.stall !== bus.instr_valid) stall_bad++;
         @(negedge clk);
      end
      bus.instr_valid = 1'b0;
      clear_inputs();
      other_en = 0;
      for (int i = 0; i < 5; i++) if (!(fu && i == unit)) other_en += en_cnt[i];

      tests_run++;
      if (!got_ready) begin
         tests_failed++; $display("FAIL %s ready_return got=never exp=within_40_cycles", name);
      end
      tests_run++;
      if (busy !== exp_busy) begin
         tests_failed++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy, exp_busy);
      end
      tests_run++;
      if ((fu ? en_cnt[unit] : 0) !== exp_en) begin
         tests_failed++; $display("FAIL %s sel_en_cycles got=%0d exp=%0d", name, en_cnt[unit], exp_en);
      end
      tests_run++;
      if (other_en !== 0) begin
         tests_failed++; $display("FAIL %s other_en_cycles got=%0d exp=0", name, other_en);
      end
      tests_run++;
      if (wb_cnt !== int'(exp_wb)) begin
         tests_failed++; $display("FAIL %s wb_pulses got=%0d exp=%0d", name, wb_cnt, exp_wb);
      end
      tests_run++;
      if (vcfg_cnt !== int'(vcfg)) begin
         tests_failed++; $display("FAIL %s vconfig_pulses got=%0d exp=%0d", name, vcfg_cnt, vcfg);
      end
      tests_run++;
      if (op_bad !== 0 || stall_bad !== 0) begin
         tests_failed++; $display("FAIL %s opq_stall_errs got=%0d/%0d exp=0/0", name, op_bad, stall_bad);
      end
      tests_run++;
      if (q_vec() !== 15'd0) begin
         tests_failed++; $display("FAIL %s opq_after got=%h exp=0", name, q_vec());
      end
      tests_run++;
      if ({bus.illegal_err, bus.timeout_err} !== {m_illegal, m_timeout}) begin
         tests_failed++;
         $display("FAIL %s err_flags got=%b%b exp=%b%b", name, bus.illegal_err, bus.timeout_err, m_illegal, m_timeout);
      end
   endtask

   task automatic pulse_err_clr(input string name);
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      m_illegal = 1'b0; m_timeout = 1'b0;
      tests_run++;
      if ({bus.illegal_err, bus.timeout_err} !== 2'b00) begin
         tests_failed++; $display("FAIL %s err_clr got=%b%b exp=00", name, bus.illegal_err, bus.timeout_err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      tests_run++;
      if ({en_vec(), q_vec(), bus.wb_en, bus.vconfig_wr_en, bus.illegal_err, bus.timeout_err} !== 24'd0) begin
         tests_failed++; $display("FAIL reset_outputs got=%h exp=0",
            {en_vec(), q_vec(), bus.wb_en, bus.vconfig_wr_en, bus.illegal_err, bus.timeout_err});
      end
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.instr_ready !== 1'b1 || bus.stall !== 1'b0) begin
         tests_failed++; $display("FAIL reset_ready got=%b%b exp=10", bus.instr_ready, bus.stall);
      end
   endtask

   task automatic test_alu();
      run_instr(4'd1, 1'b0, 4'd0, 3'd0, 3'd0, 1'b0, 1'b1, 2, 1'b0, "alu_done2");
   endtask

   task automatic test_store();
      run_instr(4'd0, 1'b0, 4'd8, 3'd0, 3'd0, 1'b0, 1'b1, 3, 1'b0, "store_wr_suppressed");
      run_instr(4'd0, 1'b0, 4'd3, 3'd0, 3'd0, 1'b0, 1'b1, 2, 1'b0, "load_wb");
   endtask

   task automatic test_illegal();
      run_instr(4'd2, 1'b0, 4'd0, 3'd0, 3'd3, 1'b0, 1'b1, 1, 1'b0, "illegal_alu_red");
      pulse_err_clr("illegal_clear");
      run_instr(4'd0, 1'b0, 4'd14, 3'd0, 3'd0, 1'b0, 1'b1, 1, 1'b1, "illegal_lsu14_vs_clr");
      pulse_err_clr("illegal_clear2");
      run_instr(4'd0, 1'b0, 4'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1, 1'b0, "noop");
   endtask

   task automatic test_timeout();
      run_instr(4'd0, 1'b1, 4'd0, 3'd0, 3'd0, 1'b0, 1'b1, 100, 1'b0, "mul_timeout");
      run_instr(4'd0, 1'b1, 4'd0, 3'd0, 3'd0, 1'b0, 1'b1, int'(TO), 1'b1, "mul_done_at_limit");
   endtask

   task automatic test_vconfig();
      run_instr(4'd0, 1'b0, 4'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1, 1'b0, "vconfig");
   endtask

   task automatic test_back_to_back();
      run_instr(4'd5, 1'b0, 4'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1, 1'b0, "b2b_first");
      run_instr(4'd0, 1'b0, 4'd0, 3'd0, 3'd6, 1'b0, 1'b1, 1, 1'b0, "b2b_second");
   endtask

   task automatic test_reset_mid();
      bus.sldu_op = 3'd1; bus.reg_wr_req = 1'b1; bus.instr_valid = 1'b1;
      @(negedge clk);
      clear_inputs();
      tests_run++;
      if (bus.vsldu_clk_en !== 1'b1) begin
         tests_failed++; $display("FAIL rst_mid_en_before got=%b exp=1", bus.vsldu_clk_en);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      m_illegal = 1'b0; m_timeout = 1'b0;
      tests_run++;
      if ({en_vec(), q_vec(), bus.wb_en, bus.vconfig_wr_en, bus.illegal_err, bus.timeout_err} !== 24'd0) begin
         tests_failed++; $display("FAIL rst_mid_async got=%h exp=0",
            {en_vec(), q_vec(), bus.wb_en, bus.vconfig_wr_en, bus.illegal_err, bus.timeout_err});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.instr_ready !== 1'b1) begin
         tests_failed++; $display("FAIL rst_mid_ready got=%b exp=1", bus.instr_ready);
      end
      bus.done_vsldu = 1'b1;
      begin
         int bad = 0;
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.wb_en !== 1'b0 || bus.vsldu_clk_en !== 1'b0 || bus.instr_ready !== 1'b1) bad++;
         end
         tests_run++;
         if (bad !== 0) begin
            tests_failed++; $display("FAIL rst_mid_stray_done got=%0d_bad_cycles exp=0", bad);
         end
      end
      clear_inputs();
   endtask

   task automatic test_random();
      logic [3:0] a, l;
      logic [2:0] s, r;
      logic m, cfg;
      for (int n = 0; n < 60; n++) begin
         a = '0; l = '0; s = '0; r = '0; m = 1'b0; cfg = 1'b0;
         case ($urandom_range(0, 9))
            0: ;
            1: a = 4'($urandom_range(1, 15));
            2: m = 1'b1;
            3: r = 3'($urandom_range(1, 7));
            4: s = 3'($urandom_range(1, 7));
            5: l = 4'($urandom_range(1, 6));
            6: l = 4'($urandom_range(7, 12));
            7: cfg = 1'b1;
            8: begin
               a = 4'($urandom_range(1, 15));
               case ($urandom_range(0, 4))
                  0: m = 1'b1;
                  1: l = 4'($urandom_range(1, 12));
                  2: s = 3'($urandom_range(1, 7));
                  3: r = 3'($urandom_range(1, 7));
                  default: cfg = 1'b1;
               endcase
            end
            default: l = 4'($urandom_range(13, 15));
         endcase
         run_instr(a, m, l, s, r, cfg, 1'($urandom), int'($urandom_range(1, 6)),
                   ($urandom_range(0, 3) == 0), "random");
      end
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_alu();
      test_store();
      test_illegal();
      test_timeout();
      test_vconfig();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Global guard so a stuck run still reports and ends.
   initial begin
      #200000;
      $display("FAIL global_time_limit got=expired exp=finish");
      $fatal(1, "time limit");
   end
endmodule

// File: doc/v_issue_ctrl.md
Name: v_issue_ctrl

Overview:
- Single-issue sequencer between the vector decoder and the functional units (VALU, VMUL, VRED, VSLDU, VLSU).
- Accepts one decoded instruction at a time over a valid/ready handshake and latches its opcodes.
- Drives the per-unit clock enables (BUFGCE CE inputs) only for the selected unit, and waits for that unit's done.
- Issues a one-cycle writeback enable, stalls the base processor while busy, and aborts hung units via a timeout.

Parameters:
- TIMEOUT_CYCLES, 255, max EXEC cycles before abort; must be >=1 and < 2^CNT_W.
- CNT_W, 8, width of the EXEC cycle counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- instr_valid  in  1  decoded instruction present
- instr_ready  out  1  controller accepts the instruction this cycle
- alu_op  in  4  VALU opcode; 0 = none
- is_mul  in  1  VMUL request
- lsu_op  in  4  1..6 load, 7..12 store, 0 = none
- sldu_op  in  3  VSLDU opcode; 0 = none
- red_op  in  3  VRED opcode; 0 = none
- is_vconfig  in  1  vsetvl-type instruction
- reg_wr_req  in  1  instruction writes the vector register file
- done_valu, done_vmul, done_vred, done_vsldu, done_vload, done_store  in  1 each  unit completion
- err_clr  in  1  clears sticky error flags
- alu_op_q  out  4  latched opcode
- is_mul_q  out  1  latched opcode
- lsu_op_q  out  4  latched opcode
- sldu_op_q  out  3  latched opcode
- red_op_q  out  3  latched opcode
- valu_clk_en, vmul_clk_en, vred_clk_en, vsldu_clk_en, vlsu_clk_en  out  1 each  registered unit clock enables
- vconfig_wr_en  out  1  CSR write pulse
- wb_en  out  1  register-file writeback pulse
- stall  out  1  hold base processor
- illegal_err  out  1  sticky error flag
- timeout_err  out  1  sticky error flag

Behaviour:
- States: IDLE, CFG, EXEC, WB, ABORT. Async reset forces IDLE.
- Reset values: all *_q, clk_en, vconfig_wr_en, wb_en and error outputs = 0. The counter = 0.
- Reset mid-operation: enables drop immediately (asynchronously); the in-flight instruction is discarded.
- instr_ready = (state==IDLE). stall = instr_valid & ~instr_ready (combinational).
- Accept occurs at cycle T when instr_valid & instr_ready.
- Legality check at accept: count requests among alu_op!=0, is_mul, lsu_op!=0, sldu_op!=0, red_op!=0, is_vconfig.
  - 0 requests: no-op; stay IDLE; no pulses.
  - More than one request, or lsu_op in 13..15: illegal. illegal_err <= 1; stay IDLE; nothing latched.
  - Exactly one request, is_vconfig: go to CFG. vconfig_wr_en = 1 during cycle T+1 only. CFG -> IDLE unconditionally.
  - Exactly one request, otherwise: latch the opcodes and reg_wr_req (stores force reg_wr_req to 0); go to EXEC.
    - The selected unit's clk_en = 1 from cycle T+1. Counter cleared.
    - All other enables stay 0. lsu covers both loads and stores via vlsu_clk_en.
- EXEC:
  - Sample only the selected unit's done: valu→done_valu, mul→done_vmul, red→done_vred, sldu→done_vsldu, load→done_vload, store→done_store.
  - Done is honoured from the first EXEC cycle. Done from non-selected units is ignored.
  - On done: go to WB; the clk_en falls on the next edge.
  - No done: counter += 1. When counter == TIMEOUT_CYCLES-1 with no done: go to ABORT.
    - Done and the timeout threshold on the same cycle: done wins.
- WB: wb_en = reg_wr_req_q for exactly one cycle. Clear *_q. Go to IDLE.
  - Minimum accept-to-accept spacing for an FU instruction with a 1-cycle unit: 3 cycles (EXEC, WB, IDLE).
- ABORT: clk_en = 0, wb_en = 0, timeout_err <= 1, clear *_q, go to IDLE.
- Error flags: sticky; cleared by err_clr (synchronous) or rst. Errors do not block issue.
  - err_clr and a new error in the same cycle: the error wins (flag stays 1).
- Opcode outputs hold stable for the whole EXEC stay.
- Inputs are don't-care while instr_ready = 0.

Test Plan:
- Reset then alu_op=1, reg_wr_req=1, valid one cycle; done_valu at EXEC cycle 2 -> valu_clk_en=1 for 2 cycles; wb_en one pulse; instr_ready back to 1 after 4 cycles; other enables 0.
- lsu_op=8 (store), reg_wr_req=1; done_store after 5 cycles -> vlsu_clk_en=1 for 5 cycles; wb_en stays 0.
- alu_op=2 with red_op=3 together -> illegal_err=1; no enable; ready stays 1. Then err_clr -> flag returns to 0.
- TIMEOUT_CYCLES=4, is_mul with no done -> vmul_clk_en high 4 cycles; timeout_err=1; wb_en=0; IDLE. Repeat with done_vmul on the 4th cycle -> done wins, no timeout_err.
- is_vconfig accepted -> vconfig_wr_en pulses once at T+1; ready low 1 cycle; no clk_en.
- sldu_op=1 in EXEC, assert rst mid-run -> all outputs 0 asynchronously; after release, ready=1 and state IDLE; done_vsldu without a valid accept produces no wb_en.
